bram_rw_stage: RTL and testbench

Simple-dual-port BRAM stage that consumes the write-data / write-address / read-address stream produced by the BRAM-tree address/data counter. It stores each write and returns read data with a fixed, parameterised latency. It also tags each read result with its address and counts same-cycle read/write address collisions. It is the memory stage of the BRAM-tree datapath; downstream compare/sort logic consumes its `o_r_*` outputs.

---
 rtl/bram_tree_pkg.sv | 31 +++
 rtl/sdp_ram.sv | 47 ++++
 rtl/bram_rw_stage.sv | 165 ++++++++++++++++
 tb/tb_bram_rw_stage.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_tree_pkg.sv
// ============================================================================
//  Module      : bram_tree_pkg
//  Description : Shared definitions for the BRAM-tree datapath (address/data
//                counter, memory stage, downstream compare/sort stages).
//                Holds default sizes, the collision-counter width, common
//                typedefs and the saturating-increment helper.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bram_tree_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int RAM_DEPTH_DEF  = 256;
    localparam int ADDR_W_DEF     = $clog2(RAM_DEPTH_DEF);
    localparam int COLL_CNT_W     = 16;

    typedef logic [ADDR_W_DEF-1:0]     addr_t;
    typedef logic [DATA_WIDTH_DEF-1:0] word_t;
    typedef logic [COLL_CNT_W-1:0]     coll_cnt_t;

    // Increment that sticks at all-ones instead of wrapping to zero.
    function automatic coll_cnt_t coll_cnt_inc(input coll_cnt_t cnt);
        coll_cnt_t nxt;
        nxt = (cnt == {COLL_CNT_W{1'b1}}) ? cnt : cnt + coll_cnt_t'(1);
        return nxt;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sdp_ram.sv
// ============================================================================
//  Module      : sdp_ram
//  Description : Inferred simple-dual-port RAM. One write port, one
//                synchronous read port (read-first on an address collision),
//                no reset on the array or the read register so that the
//                structure maps onto a block RAM primitive.
//  Ports       : clk                  - clock, rising edge
//                i_w_en/i_w_addr/i_w_data - write port
//                i_r_en/i_r_addr      - read port request
//                o_r_data             - registered read data (held when idle)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sdp_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int RAM_DEPTH  = 256,
    parameter int ADDR_W     = $clog2(RAM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  i_w_en,
    input  logic [ADDR_W-1:0]     i_w_addr,
    input  logic [DATA_WIDTH-1:0] i_w_data,
    input  logic                  i_r_en,
    input  logic [ADDR_W-1:0]     i_r_addr,
    output logic [DATA_WIDTH-1:0] o_r_data
);

    logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_q;

    // Array and read register are written in one process in the canonical
    // inference template; non-blocking semantics give read-first behaviour.
    always_ff @(posedge clk) begin
        if (i_w_en) begin
            mem[i_w_addr] <= i_w_data;
        end
        if (i_r_en) begin
            rd_data_q <= mem[i_r_addr];
        end
    end

    assign o_r_data = rd_data_q;

endmodule

`default_nettype wire

// File: rtl/bram_rw_stage.sv
// ============================================================================
//  Module      : bram_rw_stage
//  Description : Memory stage of the BRAM-tree datapath. Stores each write,
//                returns read data tagged with its address after a fixed
//                latency (1 with OUT_REG=0, 2 with OUT_REG=1) and counts
//                same-cycle read/write address collisions (saturating).
//  Build macro : BRAM_RW_BYPASS_EN - when defined, a collision forwards the
//                write data to the read result (write-first); otherwise the
//                old stored word is returned (read-first).
//  Ports       : CLK, RST_N (async assert, active-low)
//                i_w_en/i_w_data/i_w_addr - write request
//                i_r_en/i_r_addr          - read request
//                o_r_data/o_r_valid/o_r_addr - read result beat
//                o_coll_cnt               - saturating collision count
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bram_rw_stage
    import bram_tree_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int RAM_DEPTH  = RAM_DEPTH_DEF,
    parameter int OUT_REG    = 1,
    localparam int ADDR_W    = $clog2(RAM_DEPTH)
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  i_w_en,
    input  logic [DATA_WIDTH-1:0] i_w_data,
    input  logic [ADDR_W-1:0]     i_w_addr,
    input  logic                  i_r_en,
    input  logic [ADDR_W-1:0]     i_r_addr,
    output logic [DATA_WIDTH-1:0] o_r_data,
    output logic                  o_r_valid,
    output logic [ADDR_W-1:0]     o_r_addr,
    output logic [15:0]           o_coll_cnt
);

    logic                  coll;
    logic [DATA_WIDTH-1:0] ram_rd_data;
    logic [DATA_WIDTH-1:0] s1_data;

    logic                  v1_d,   v1_q;
    logic [ADDR_W-1:0]     tag1_d, tag1_q;
    coll_cnt_t             cnt_d,  cnt_q;

    assign coll = i_w_en & i_r_en & (i_w_addr == i_r_addr);

    sdp_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .RAM_DEPTH  (RAM_DEPTH),
        .ADDR_W     (ADDR_W)
    ) u_ram (
        .clk      (CLK),
        .i_w_en   (i_w_en),
        .i_w_addr (i_w_addr),
        .i_w_data (i_w_data),
        .i_r_en   (i_r_en),
        .i_r_addr (i_r_addr),
        .o_r_data (ram_rd_data)
    );

    // Stage 1: valid/tag aligned with the RAM read register. The tag only
    // moves on a read so it stays aligned with the held RAM output.
    always_comb begin
        v1_d   = i_r_en;
        tag1_d = i_r_en ? i_r_addr : tag1_q;
        cnt_d  = coll ? coll_cnt_inc(cnt_q) : cnt_q;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            v1_q   <= 1'b0;
            tag1_q <= '0;
            cnt_q  <= '0;
        end else begin
            v1_q   <= v1_d;
            tag1_q <= tag1_d;
            cnt_q  <= cnt_d;
        end
    end

    assign o_coll_cnt = cnt_q;

`ifdef BRAM_RW_BYPASS_EN
    // Write-first forwarding: remember whether the last read collided and
    // what was written, then steer that copy past the read-first RAM.
    logic                  byp_sel_d,  byp_sel_q;
    logic [DATA_WIDTH-1:0] byp_data_d, byp_data_q;

    always_comb begin
        byp_sel_d  = i_r_en ? coll : byp_sel_q;
        byp_data_d = coll ? i_w_data : byp_data_q;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            byp_sel_q  <= 1'b0;
            byp_data_q <= '0;
        end else begin
            byp_sel_q  <= byp_sel_d;
            byp_data_q <= byp_data_d;
        end
    end

    assign s1_data = byp_sel_q ? byp_data_q : ram_rd_data;
`else
    assign s1_data = ram_rd_data;
`endif

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic                  v2_d,    v2_q;
            logic [ADDR_W-1:0]     tag2_d,  tag2_q;
            logic [DATA_WIDTH-1:0] data2_d, data2_q;

            // Captured copy: later writes to the same address cannot leak in.
            always_comb begin
                v2_d    = v1_q;
                tag2_d  = v1_q ? tag1_q  : tag2_q;
                data2_d = v1_q ? s1_data : data2_q;
            end

            always_ff @(posedge CLK or negedge RST_N) begin
                if (!RST_N) begin
                    v2_q    <= 1'b0;
                    tag2_q  <= '0;
                    data2_q <= '0;
                end else begin
                    v2_q    <= v2_d;
                    tag2_q  <= tag2_d;
                    data2_q <= data2_d;
                end
            end

            assign o_r_valid = v2_q;
            assign o_r_addr  = tag2_q;
            assign o_r_data  = data2_q;
        end else begin : g_no_out_reg
            // The RAM read register has no reset, so the output is forced to
            // zero until the first read after reset has landed.
            logic have_data_d, have_data_q;

            always_comb begin
                have_data_d = have_data_q | i_r_en;
            end

            always_ff @(posedge CLK or negedge RST_N) begin
                if (!RST_N) begin
                    have_data_q <= 1'b0;
                end else begin
                    have_data_q <= have_data_d;
                end
            end

            assign o_r_valid = v1_q;
            assign o_r_addr  = tag1_q;
            assign o_r_data  = have_data_q ? s1_data : '0;
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_bram_rw_stage.sv
// ============================================================================
//  Module      : tb_bram_rw_stage
//  Description : Self-checking bench for bram_rw_stage. Two instances run in
//                lockstep on the same stimulus (OUT_REG=0 and OUT_REG=1);
//                a memory-array reference model with per-beat due times
//                predicts every output cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bram_rw_stage;

    localparam int DW    = 32;
    localparam int AW    = 8;
    localparam int DEPTH = 256;
`ifdef BRAM_RW_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic          CLK = 1'b0;
    logic          RST_N = 1'b0;
    logic          w_en = 1'b0;
    logic [DW-1:0] w_data = '0;
    logic [AW-1:0] w_addr = '0;
    logic          r_en = 1'b0;
    logic [AW-1:0] r_addr = '0;

    logic [DW-1:0] r1_data, r2_data;
    logic          r1_valid, r2_valid;
    logic [AW-1:0] r1_addr, r2_addr;
    logic [15:0]   cnt1, cnt2;

    always #5 CLK = ~CLK;

    bram_rw_stage #(.DATA_WIDTH(DW), .RAM_DEPTH(DEPTH), .OUT_REG(0)) dut1 (
        .CLK(CLK), .RST_N(RST_N),
        .i_w_en(w_en), .i_w_data(w_data), .i_w_addr(w_addr),
        .i_r_en(r_en), .i_r_addr(r_addr),
        .o_r_data(r1_data), .o_r_valid(r1_valid), .o_r_addr(r1_addr),
        .o_coll_cnt(cnt1)
    );

    bram_rw_stage #(.DATA_WIDTH(DW), .RAM_DEPTH(DEPTH), .OUT_REG(1)) dut2 (
        .CLK(CLK), .RST_N(RST_N),
        .i_w_en(w_en), .i_w_data(w_data), .i_w_addr(w_addr),
        .i_r_en(r_en), .i_r_addr(r_addr),
        .o_r_data(r2_data), .o_r_valid(r2_valid), .o_r_addr(r2_addr),
        .o_coll_cnt(cnt2)
    );

    // ---------------- reference model ----------------
    typedef struct {
        int            due;
        logic [DW-1:0] data;
        logic [AW-1:0] addr;
        bit            known;
    } beat_t;

    beat_t         q1[$];
    beat_t         q2[$];
    logic [DW-1:0] mem_m [DEPTH];
    bit            mem_k [DEPTH];
    int            cyc;
    logic [15:0]   cnt_m;

    bit            ev1, ev2, ek1, ek2;
    logic [DW-1:0] ed1, ed2;
    logic [AW-1:0] ea1, ea2;

    int checks   = 0;
    int failures = 0;

    task automatic model_reset();
        q1.delete();
        q2.delete();
        ev1 = 0; ev2 = 0;
        ek1 = 1; ek2 = 1;
        ed1 = '0; ed2 = '0;
        ea1 = '0; ea2 = '0;
        cnt_m = '0;
    endtask

    // Drive one request cycle (called at a falling edge), advance the model,
    // and leave the expected outputs for the cycle after the rising edge.
    task automatic tick(input bit we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                        input bit re, input logic [AW-1:0] ra);
        beat_t b;
        w_en = we; w_addr = wa; w_data = wd;
        r_en = re; r_addr = ra;
        if (re) begin
            b.addr = ra;
            if (we && wa == ra && BYPASS) begin
                b.data  = wd;
                b.known = 1;
            end else begin
                b.data  = mem_m[ra];
                b.known = mem_k[ra];
            end
            b.due = cyc + 1; q1.push_back(b);
            b.due = cyc + 2; q2.push_back(b);
        end
        if (we && re && wa == ra && cnt_m != 16'hFFFF) cnt_m = cnt_m + 16'd1;
        if (we) begin
            mem_m[wa] = wd;
            mem_k[wa] = 1;
        end
        @(posedge CLK);
        cyc++;
        @(negedge CLK);
        ev1 = 0;
        if (q1.size() > 0 && q1[0].due == cyc) begin
            b = q1.pop_front();
            ev1 = 1; ed1 = b.data; ea1 = b.addr; ek1 = b.known;
        end
        ev2 = 0;
        if (q2.size() > 0 && q2[0].due == cyc) begin
            b = q2.pop_front();
            ev2 = 1; ed2 = b.data; ea2 = b.addr; ek2 = b.known;
        end
    endtask

    task automatic idle();
        tick(0, '0, '0, 0, '0);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        RST_N = 0;
        model_reset();
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        checks++;
        if (r1_valid !== 1'b0 || r1_data !== '0 || r1_addr !== '0 || cnt1 !== '0 ||
            r2_valid !== 1'b0 || r2_data !== '0 || r2_addr !== '0 || cnt2 !== '0) begin
            failures++;
            $display("FAIL reset_values lat1 v/a/d/c=%0b/%0h/%0h/%0h lat2 v/a/d/c=%0b/%0h/%0h/%0h required all 0",
                     r1_valid, r1_addr, r1_data, cnt1, r2_valid, r2_addr, r2_data, cnt2);
        end
        RST_N = 1;
        cyc = 0;
    endtask

    task automatic test_basic();
        for (int i = 0; i < 11; i++) begin
            if (i < 4)      tick(1, AW'(i), DW'(10 + i), 0, '0);
            else if (i < 8) tick(0, '0, '0, 1, AW'(i - 4));
            else            idle();
            checks++;
            if (r1_valid !== ev1 || r1_addr !== ea1 || (ek1 && r1_data !== ed1) ||
                r2_valid !== ev2 || r2_addr !== ea2 || (ek2 && r2_data !== ed2)) begin
                failures++;
                $display("FAIL basic cyc=%0d lat1 v/a/d=%0b/%0h/%0h req %0b/%0h/%0h lat2 v/a/d=%0b/%0h/%0h req %0b/%0h/%0h",
                         cyc, r1_valid, r1_addr, r1_data, ev1, ea1, ed1, r2_valid, r2_addr, r2_data, ev2, ea2, ed2);
            end
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 7; i++) begin
            case (i)
                0: tick(1, 8'd255, 32'hAA, 0, '0);
                1: tick(1, 8'd0,   32'hBB, 0, '0);
                2: tick(0, '0, '0, 1, 8'd255);
                3: tick(0, '0, '0, 1, 8'd0);
                default: idle();
            endcase
            checks++;
            if (r1_valid !== ev1 || r1_addr !== ea1 || (ek1 && r1_data !== ed1) ||
                r2_valid !== ev2 || r2_addr !== ea2 || (ek2 && r2_data !== ed2)) begin
                failures++;
                $display("FAIL wrap cyc=%0d lat1 v/a/d=%0b/%0h/%0h req %0b/%0h/%0h lat2 v/a/d=%0b/%0h/%0h req %0b/%0h/%0h",
                         cyc, r1_valid, r1_addr, r1_data, ev1, ea1, ed1, r2_valid, r2_addr, r2_data, ev2, ea2, ed2);
            end
        end
    endtask

    task automatic test_collision();
        for (int i = 0; i < 9; i++) begin
            case (i)
                0: tick(1, 8'd5, 32'h11, 0, '0);
                1: tick(1, 8'd5, 32'h22, 1, 8'd5);
                5: tick(0, '0, '0, 1, 8'd5);
                default: idle();
            endcase
            checks++;
            if (r1_valid !== ev1 || r1_addr !== ea1 || (ek1 && r1_data !== ed1) ||
                r2_valid !== ev2 || r2_addr !== ea2 || (ek2 && r2_data !== ed2) ||
                cnt1 !== cnt_m || cnt2 !== cnt_m) begin
                failures++;
                $display("FAIL collision cyc=%0d lat1 v/a/d=%0b/%0h/%0h req %0b/%0h/%0h lat2 v/a/d=%0b/%0h/%0h req %0b/%0h/%0h cnt %0h/%0h req %0h",
                         cyc, r1_valid, r1_addr, r1_data, ev1, ea1, ed1, r2_valid, r2_addr, r2_data, ev2, ea2, ed2,
                         cnt1, cnt2, cnt_m);
            end
        end
        checks++;
        if (cnt1 !== 16'd1 || cnt2 !== 16'd1) begin
            failures++;
            $display("FAIL collision_count got %0h/%0h required 1", cnt1, cnt2);
        end
    endtask

    task automatic test_stream();
        for (int i = 0; i < 1024 + 4; i++) begin
            if (i < 1024) tick(1, AW'(i), $urandom, i >= 8, AW'(i - 8));
            else          idle();
            checks++;
            if (r1_valid !== ev1 || r1_addr !== ea1 || (ek1 && r1_data !== ed1) ||
                r2_valid !== ev2 || r2_addr !== ea2 || (ek2 && r2_data !== ed2) ||
                cnt1 !== cnt_m || cnt2 !== cnt_m) begin
                failures++;
                $display("FAIL stream cyc=%0d lat1 v/a/d=%0b/%0h/%0h req %0b/%0h/%0h lat2 v/a/d=%0b/%0h/%0h req %0b/%0h/%0h",
                         cyc, r1_valid, r1_addr, r1_data, ev1, ea1, ed1, r2_valid, r2_addr, r2_data, ev2, ea2, ed2);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            tick(bit'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), $urandom,
                 bit'($urandom_range(0, 1)), AW'($urandom_range(0, 15)));
            checks++;
            if (r1_valid !== ev1 || r1_addr !== ea1 || (ek1 && r1_data !== ed1) ||
                r2_valid !== ev2 || r2_addr !== ea2 || (ek2 && r2_data !== ed2) ||
                cnt1 !== cnt_m || cnt2 !== cnt_m) begin
                failures++;
                $display("FAIL random cyc=%0d lat1 v/a/d=%0b/%0h/%0h req %0b/%0h/%0h lat2 v/a/d=%0b/%0h/%0h req %0b/%0h/%0h cnt %0h/%0h req %0h",
                         cyc, r1_valid, r1_addr, r1_data, ev1, ea1, ed1, r2_valid, r2_addr, r2_data, ev2, ea2, ed2,
                         cnt1, cnt2, cnt_m);
            end
        end
    endtask

    task automatic test_reset_midflight();
        tick(0, '0, '0, 1, 8'd1);
        tick(0, '0, '0, 1, 8'd2);
        checks++;
        if (r1_valid !== 1'b1 || r2_valid !== 1'b1) begin
            failures++;
            $display("FAIL midflight_pre valid %0b/%0b required 1/1", r1_valid, r2_valid);
        end
        RST_N = 0;
        r_en  = 0;
        model_reset();
        #1;
        checks++;
        if (r1_valid !== 1'b0 || r2_valid !== 1'b0 || r1_data !== '0 || r2_data !== '0 ||
            r1_addr !== '0 || r2_addr !== '0 || cnt1 !== '0 || cnt2 !== '0) begin
            failures++;
            $display("FAIL midflight_async v %0b/%0b d %0h/%0h a %0h/%0h c %0h/%0h required all 0",
                     r1_valid, r2_valid, r1_data, r2_data, r1_addr, r2_addr, cnt1, cnt2);
        end
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST_N = 1;
        for (int i = 0; i < 8; i++) begin
            if (i == 4) tick(0, '0, '0, 1, 8'd3);
            else        idle();
            checks++;
            if (r1_valid !== ev1 || r1_addr !== ea1 || (ek1 && r1_data !== ed1) ||
                r2_valid !== ev2 || r2_addr !== ea2 || (ek2 && r2_data !== ed2)) begin
                failures++;
                $display("FAIL midflight_after cyc=%0d lat1 v/a/d=%0b/%0h/%0h req %0b/%0h/%0h lat2 v/a/d=%0b/%0h/%0h req %0b/%0h/%0h",
                         cyc, r1_valid, r1_addr, r1_data, ev1, ea1, ed1, r2_valid, r2_addr, r2_data, ev2, ea2, ed2);
            end
        end
    endtask

    task automatic test_saturation();
        logic [AW-1:0] a;
        for (int i = 0; i < 70000; i++) begin
            a = AW'($urandom);
            tick(1, a, $urandom, 1, a);
            if (i == 65533 || i == 65534 || i == 69999) begin
                checks++;
                if (cnt1 !== cnt_m || cnt2 !== cnt_m) begin
                    failures++;
                    $display("FAIL saturation_step i=%0d cnt %0h/%0h required %0h", i, cnt1, cnt2, cnt_m);
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            idle();
            checks++;
            if (cnt1 !== 16'hFFFF || cnt2 !== 16'hFFFF) begin
                failures++;
                $display("FAIL saturation_hold cnt %0h/%0h required ffff", cnt1, cnt2);
            end
        end
    endtask

    initial begin
        cyc = 0;
        for (int i = 0; i < DEPTH; i++) begin
            mem_m[i] = '0;
            mem_k[i] = 0;
        end
        test_reset();
        test_basic();
        test_wrap();
        test_collision();
        test_stream();
        test_random();
        test_reset_midflight();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
